// File: rtl/cla_adder_16.sv
// cla_adder_16: 16-bit two-level carry-lookahead adder with one output register stage.
// Four 4-bit lookahead groups produce group generate/propagate terms. A second-level
// lookahead unit turns these into the group carry-ins and the final carry-out.
// No carry ripples inside a group or between groups.
module cla_adder_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        carry_in,
   output logic [15:0] sum,
   output logic        carry_out,
   output logic        out_valid
);

   logic [15:0] g;          // bit generate
   logic [15:0] p;          // bit propagate
   logic [15:0] c;          // carry into each bit
   logic [3:0]  group_gen;  // group generate (GG)
   logic [3:0]  group_prop; // group propagate (GP)
   logic [3:0]  group_cin;  // carry into each group from the second-level unit
   logic        c16;        // carry out of bit 15
   logic [15:0] sum_next;

   assign g = a & b;
   assign p = a ^ b;

   // First level: in-group carries and group generate/propagate, all written as flat
   // sum-of-products so that every carry is two gate levels from g/p and the group carry-in.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_group
         logic [3:0] gg;
         logic [3:0] pp;
         logic       cin;

         assign gg  = g[4*gi +: 4];
         assign pp  = p[4*gi +: 4];
         assign cin = group_cin[gi];

         assign c[4*gi]     = cin;
         assign c[4*gi + 1] = gg[0]
                            | (pp[0] & cin);
         assign c[4*gi + 2] = gg[1]
                            | (pp[1] & gg[0])
                            | (pp[1] & pp[0] & cin);
         assign c[4*gi + 3] = gg[2]
                            | (pp[2] & gg[1])
                            | (pp[2] & pp[1] & gg[0])
                            | (pp[2] & pp[1] & pp[0] & cin);

         assign group_gen[gi]  = gg[3]
                               | (pp[3] & gg[2])
                               | (pp[3] & pp[2] & gg[1])
                               | (pp[3] & pp[2] & pp[1] & gg[0]);
         assign group_prop[gi] = &pp;
      end
   endgenerate

   // Second level: group carries c0/c4/c8/c12 and c16, computed directly from GG/GP and carry_in.
   assign group_cin[0] = carry_in;
   assign group_cin[1] = group_gen[0]
                       | (group_prop[0] & carry_in);
   assign group_cin[2] = group_gen[1]
                       | (group_prop[1] & group_gen[0])
                       | (group_prop[1] & group_prop[0] & carry_in);
   assign group_cin[3] = group_gen[2]
                       | (group_prop[2] & group_gen[1])
                       | (group_prop[2] & group_prop[1] & group_gen[0])
                       | (group_prop[2] & group_prop[1] & group_prop[0] & carry_in);
   assign c16          = group_gen[3]
                       | (group_prop[3] & group_gen[2])
                       | (group_prop[3] & group_prop[2] & group_gen[1])
                       | (group_prop[3] & group_prop[2] & group_prop[1] & group_gen[0])
                       | (group_prop[3] & group_prop[2] & group_prop[1] & group_prop[0] & carry_in);

   assign sum_next = p ^ c;

   // Output stage: load the result on a valid cycle and hold it otherwise.
   // out_valid marks only the cycle directly after the input was accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         carry_out <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum       <= sum_next;
            carry_out <= c16;
         end
      end
   end

endmodule

// File: tb/tb_cla_adder_16.sv
// Self-checking bench for cla_adder_16. Expected results come from a plain 17-bit add.
// They are pushed to a queue when the input is driven and popped one cycle later.
module tb_cla_adder_16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic        carry_in;
   logic [15:0] sum;
   logic        carry_out;
   logic        out_valid;

   int unsigned n_vec;
   int unsigned n_err;
   logic [16:0] exp_q[$];

   cla_adder_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sum       (sum),
      .carry_out (carry_out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one valid input, record its expected result, and advance to 1 time unit after the edge.
   task automatic apply(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
      a        = ta;
      b        = tb_v;
      carry_in = tc;
      in_valid = 1'b1;
      exp_q.push_back({1'b0, ta} + {1'b0, tb_v} + 17'(tc));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [16:0] got;
      #1;
      got = {carry_out, sum};
      n_vec++;
      if (got !== 17'd0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got co/sum=%h valid=%b, want 00000 valid=0", got, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: got valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_basic();
      logic [16:0] got;
      logic [16:0] exp;
      apply(16'd10, 16'd22, 1'b0);
      exp = exp_q.pop_front();
      got = {carry_out, sum};
      n_vec++;
      if (out_valid !== 1'b1 || got !== exp || exp !== 17'd32) begin
         n_err++;
         $display("FAIL basic_10_22: got %0d valid=%b, want %0d (32)", got, out_valid, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va[4] = '{16'd120, 16'd928, 16'd7, 16'h000F};
      logic [15:0] vb[4] = '{16'd82, 16'd910, 16'd1, 16'h0001};
      logic        vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [16:0] want[4] = '{17'd202, 17'd1839, 17'd9, 17'h00010};
      logic [16:0] got;
      logic [16:0] exp;
      for (int i = 0; i < 4; i++) begin
         apply(va[i], vb[i], vc[i]);
         exp = exp_q.pop_front();
         got = {carry_out, sum};
         n_vec++;
         if (out_valid !== 1'b1 || got !== exp || exp !== want[i]) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: got %h valid=%b, want %h", i, got, out_valid, want[i]);
         end
      end
   endtask

   task automatic test_boundary();
      logic [15:0] va[4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0FFF};
      logic [15:0] vb[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};
      logic        vc[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [16:0] want[4] = '{17'h10000, 17'h1FFFF, 17'h10000, 17'h01000};
      logic [16:0] got;
      logic [16:0] exp;
      for (int i = 0; i < 4; i++) begin
         apply(va[i], vb[i], vc[i]);
         exp = exp_q.pop_front();
         got = {carry_out, sum};
         n_vec++;
         if (out_valid !== 1'b1 || got !== exp || exp !== want[i]) begin
            n_err++;
            $display("FAIL boundary[%0d]: got %h valid=%b, want %h", i, got, out_valid, want[i]);
         end
      end
      // zero plus carry-in only
      apply(16'h0000, 16'h0000, 1'b1);
      exp = exp_q.pop_front();
      got = {carry_out, sum};
      n_vec++;
      if (out_valid !== 1'b1 || got !== exp || exp !== 17'd1) begin
         n_err++;
         $display("FAIL zero_plus_cin: got %h valid=%b, want 00001", got, out_valid);
      end
   endtask

   task automatic test_hold();
      logic [16:0] got;
      logic [16:0] held;
      apply(16'h1234, 16'hF111, 1'b1);
      held = exp_q.pop_front();
      got  = {carry_out, sum};
      n_vec++;
      if (out_valid !== 1'b1 || got !== held) begin
         n_err++;
         $display("FAIL hold_load: got %h valid=%b, want %h", got, out_valid, held);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a        = 16'hA5A5 + 16'(i);
         b        = 16'h5A5A;
         carry_in = 1'b1;
         @(posedge clk);
         #1;
         got = {carry_out, sum};
         n_vec++;
         if (out_valid !== 1'b0 || got !== held) begin
            n_err++;
            $display("FAIL hold[%0d]: got %h valid=%b, want %h valid=0", i, got, out_valid, held);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [16:0] got;
      // Load a nonzero result, then pull reset between edges.
      apply(16'hFFFF, 16'h0002, 1'b0);
      void'(exp_q.pop_front());
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      got = {carry_out, sum};
      n_vec++;
      if (got !== 17'd0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got %h valid=%b, want 00000 valid=0", got, out_valid);
      end
      // A valid input presented while reset is held must be discarded.
      a        = 16'h4321;
      b        = 16'h1111;
      carry_in = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      got = {carry_out, sum};
      n_vec++;
      if (got !== 17'd0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_discard: got %h valid=%b, want 00000 valid=0", got, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || {carry_out, sum} !== 17'd0) begin
         n_err++;
         $display("FAIL reset_release: got %h valid=%b, want 00000 valid=0", {carry_out, sum}, out_valid);
      end
   endtask

   task automatic test_corners();
      logic [15:0] cv[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
      logic [16:0] got;
      logic [16:0] exp;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 2; k++) begin
               apply(cv[i], cv[j], k[0]);
               exp = exp_q.pop_front();
               got = {carry_out, sum};
               n_vec++;
               if (out_valid !== 1'b1 || got !== exp) begin
                  n_err++;
                  $display("FAIL corner %h+%h+%0d: got %h valid=%b, want %h",
                           cv[i], cv[j], k, got, out_valid, exp);
               end
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] r;
      logic [16:0] got;
      logic [16:0] exp;
      logic [15:0] ra;
      logic [15:0] rb;
      for (int i = 0; i < 10000; i++) begin
         r  = $urandom;
         ra = r[15:0];
         rb = r[31:16];
         r  = $urandom;
         apply(ra, rb, r[0]);
         exp = exp_q.pop_front();
         got = {carry_out, sum};
         n_vec++;
         if (out_valid !== 1'b1 || got !== exp) begin
            n_err++;
            $display("FAIL random[%0d] %h+%h+%0d: got %h valid=%b, want %h",
                     i, ra, rb, r[0], got, out_valid, exp);
         end
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      carry_in = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_boundary();
      test_hold();
      test_async_reset();
      test_corners();
      test_random();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
